// File: rtl/button_debouncer_pkg.sv
// Shared types and constants for the push-button conditioning front end.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } dbnc_state_e;

    // 10 ms of stability at a 100 MHz clock.
    localparam int DEFAULT_N_COUNT = 1000000;

    // Keeps the counter at least one bit wide so N_COUNT=1 still elaborates.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debouncer_debounce_fsm.sv
// One button: 2-flop synchronizer, stable-time counter and press/release FSM.
// Press request is combinational and coincides with the edge that enters PRESSED.
module debounce_fsm
    import button_debouncer_pkg::*;
#(
    parameter int N_COUNT  = DEFAULT_N_COUNT,
    parameter int CNT_BITS = cnt_width(DEFAULT_N_COUNT)
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_req_o
);

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(N_COUNT - 1);

    logic                sync1_q;
    logic                sync2_q;
    dbnc_state_e         state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                level_q, level_d;
    logic                cnt_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign cnt_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sync2_q) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync2_q)     state_d = ST_IDLE;
                else if (cnt_last) state_d = ST_PRESSED;
                else               cnt_d   = cnt_q + CNT_BITS'(1);
            end
            ST_PRESSED: begin
                if (!sync2_q) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                // A return to high is release bounce: back to PRESSED without a new request.
                if (sync2_q)       state_d = ST_PRESSED;
                else if (cnt_last) state_d = ST_IDLE;
                else               cnt_d   = cnt_q + CNT_BITS'(1);
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        press_req_o = (state_q == ST_PRESS_WAIT) && sync2_q && cnt_last;
        level_d     = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
    end

    assign level_o = level_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces N_B buttons and emits registered one-hot press strobes; on simultaneous
// requests the highest index wins and the others are consumed without replay.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int N_B     = 3,
    parameter int N_COUNT = DEFAULT_N_COUNT
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N_B-1:0] i_btn_raw,
    output logic [N_B-1:0] o_pulse,
    output logic [N_B-1:0] o_level
);

    localparam int N_CNT_BITS = cnt_width(N_COUNT);

    logic [N_B-1:0] press_req;
    logic [N_B-1:0] pulse_d, pulse_q;

    for (genvar g = 0; g < N_B; g++) begin : g_btn
        debounce_fsm #(
            .N_COUNT  (N_COUNT),
            .CNT_BITS (N_CNT_BITS)
        ) u_fsm (
            .clock       (clock),
            .reset       (reset),
            .btn_raw_i   (i_btn_raw[g]),
            .level_o     (o_level[g]),
            .press_req_o (press_req[g])
        );
    end

    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < N_B; i++) begin
            if (press_req[i]) begin
                pulse_d    = '0;
                pulse_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) pulse_q <= '0;
        else       pulse_q <= pulse_d;
    end

    assign o_pulse = pulse_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed vector bench for button_debouncer with N_COUNT=4, N_B=3.
module tb_button_debouncer;

    localparam int NB = 3;

    typedef struct {
        logic [NB-1:0] raw;
        logic [NB-1:0] exp_pulse;
        logic [NB-1:0] exp_level;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] i_btn_raw = '0;
    logic [NB-1:0] o_pulse;
    logic [NB-1:0] o_level;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    button_debouncer #(.N_B(NB), .N_COUNT(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .i_btn_raw (i_btn_raw),
        .o_pulse   (o_pulse),
        .o_level   (o_level)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int idx, input logic [NB-1:0] act,
                         input logic [NB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic [NB-1:0] r, input logic [NB-1:0] p, input logic [NB-1:0] l);
        vec_t v;
        v.raw = r; v.exp_pulse = p; v.exp_level = l;
        vecs.push_back(v);
    endtask

    initial begin
        // Entry k: raw is sampled at edge k; expectations hold just after edge k.
        // Clean press on button 2, released after 20 samples.
        for (int e = 0; e < 32; e++)
            add(e < 20 ? 3'b100 : 3'b000, e == 6 ? 3'b100 : 3'b000,
                (e >= 6 && e < 26) ? 3'b100 : 3'b000);
        // Press bounce on button 1: 1,0,1,0,1 then held; final rise at edge 4.
        for (int e = 0; e < 30; e++)
            add(e < 5 ? ((e % 2 == 0) ? 3'b010 : 3'b000) : (e < 16 ? 3'b010 : 3'b000),
                e == 10 ? 3'b010 : 3'b000, (e >= 10 && e < 22) ? 3'b010 : 3'b000);
        // Three-sample glitch on button 0.
        for (int e = 0; e < 12; e++)
            add(e < 3 ? 3'b001 : 3'b000, 3'b000, 3'b000);
        // Button 0 held with a two-sample release bounce.
        for (int e = 0; e < 35; e++)
            add((e < 12) ? 3'b001 : (e < 14) ? 3'b000 : (e < 25) ? 3'b001 : 3'b000,
                e == 6 ? 3'b001 : 3'b000, (e >= 6 && e < 31) ? 3'b001 : 3'b000);
        // Simultaneous press of buttons 0 and 2.
        for (int e = 0; e < 32; e++)
            add(e < 20 ? 3'b101 : 3'b000, e == 6 ? 3'b100 : 3'b000,
                (e >= 6 && e < 26) ? 3'b101 : 3'b000);

        #2;
        check("reset_pulse", 0, o_pulse, 3'b000);
        check("reset_level", 0, o_level, 3'b000);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[k]) begin
            i_btn_raw = vecs[k].raw;
            @(posedge clock);
            @(negedge clock);
            check("vec_pulse", k, o_pulse, vecs[k].exp_pulse);
            check("vec_level", k, o_level, vecs[k].exp_level);
        end

        // Async reset: button 2 pulses at edge 6 while button 0 is mid-PRESS_WAIT.
        i_btn_raw = 3'b100;
        for (int e = 0; e <= 6; e++) begin
            if (e == 2) i_btn_raw = 3'b101;
            @(posedge clock);
        end
        #1;
        check("pre_reset_pulse", 6, o_pulse, 3'b100);
        check("pre_reset_level", 6, o_level, 3'b100);
        #1 reset = 1'b1;
        #1;
        check("async_reset_pulse", 0, o_pulse, 3'b000);
        check("async_reset_level", 0, o_level, 3'b000);
        @(posedge clock);
        @(negedge clock);
        check("held_reset_level", 0, o_level, 3'b000);
        reset = 1'b0;
        // Both still held: fresh qualification, pulse for button 2 only at edge 6'.
        for (int e = 0; e < 10; e++) begin
            @(posedge clock);
            @(negedge clock);
            check("post_reset_pulse", e, o_pulse, e == 6 ? 3'b100 : 3'b000);
            check("post_reset_level", e, o_level, e >= 6 ? 3'b101 : 3'b000);
        end
        i_btn_raw = 3'b000;
        for (int e = 0; e < 8; e++) @(posedge clock);
        @(negedge clock);
        check("final_level", 0, o_level, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
